// File: rtl/draw_board_grid_pkg.sv
// Shared types, colours and helpers for the battleship board renderer.
package board_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SHIP  = 2'd1,
        HIT   = 2'd2,
        MISS  = 2'd3
    } cell_state_t;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } wr_fsm_t;

    // One pixel's worth of timing plus colour, as carried through the pipeline.
    typedef struct packed {
        logic [10:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [10:0] vcount;
        logic        vsync;
        logic        vblnk;
        logic [11:0] rgb;
    } vga_sig_t;

    // 1024x768 visible area.
    localparam int unsigned HOR_PIXELS = 1024;
    localparam int unsigned VER_PIXELS = 768;

    localparam logic [11:0] COL_BLACK      = 12'h000;
    localparam logic [11:0] COL_WHITE      = 12'hFFF;
    localparam logic [11:0] COL_YELLOW     = 12'hFF0;
    localparam logic [11:0] COL_RED        = 12'hF00;
    localparam logic [11:0] COL_GREEN      = 12'h0F0;
    localparam logic [11:0] COL_BLUE       = 12'h00F;
    localparam logic [11:0] COL_GREY       = 12'h888;
    localparam logic [11:0] COL_BACKGROUND = 12'hFAC;

    // Empty-cell colour per board; element [0] is board 0.
    localparam logic [3:0][11:0] BOARD_COLOUR = {12'h630, 12'h306, 12'h063, 12'h036};

    // Smallest address width able to index `depth` entries (minimum 1).
    function automatic int unsigned addr_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < depth) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing and colour bundle: 11-bit counters, 12-bit rgb.
interface vga_if;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [11:0] rgb;

    modport in  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
    modport out (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
endinterface

// File: rtl/cell_state_ram.sv
// Cell-state storage: one write port, one registered read port, no reset.
module cell_state_ram #(
    parameter int unsigned DEPTH = 200,
    parameter int unsigned AW    = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [1:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [1:0]    rdata_o
);

    logic [1:0] mem_q [DEPTH];
    logic [1:0] rdata_q;

    // Write and read-before-write on the same edge.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/draw_board_grid.sv
// Draws N_BOARDS game grids with cell states and a blinking cursor over
// the incoming VGA stream; two-stage pipeline, cell RAM read in stage 0.
module draw_board_grid
    import board_pkg::*;
#(
    parameter int unsigned N_BOARDS     = 2,
    parameter int unsigned GRID_COLS    = 10,
    parameter int unsigned GRID_ROWS    = 10,
    parameter int unsigned CELL_LOG2    = 5,
    parameter int unsigned BOARD_X0     = 96,
    parameter int unsigned BOARD_PITCH  = 512,
    parameter int unsigned BOARD_Y0     = 192,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_if.in          vga_in,
    vga_if.out         vga_out,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_board,
    input  logic [3:0] wr_col,
    input  logic [3:0] wr_row,
    input  logic [1:0] wr_state,
    input  logic       clr_req,
    output logic       clr_busy,
    input  logic       cur_en,
    input  logic [1:0] cur_board,
    input  logic [3:0] cur_col,
    input  logic [3:0] cur_row
);

    localparam int unsigned CELL_PX = 32'd1 << CELL_LOG2;
    localparam int unsigned DEPTH   = N_BOARDS * GRID_COLS * GRID_ROWS;
    localparam int unsigned AW      = addr_width(DEPTH);
    localparam int unsigned BOARD_W = GRID_COLS << CELL_LOG2;
    localparam int unsigned BOARD_H = GRID_ROWS << CELL_LOG2;

    // ---------------- write / clear FSM ----------------
    wr_fsm_t       state_q;
    logic [AW-1:0] clr_addr_q;
    logic          wr_ready_q;
    logic          clr_busy_q;

    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic [1:0]    ram_wdata;
    logic          wr_in_range;

    assign wr_in_range = (32'(wr_board) < N_BOARDS) &&
                         (32'(wr_col) < GRID_COLS) &&
                         (32'(wr_row) < GRID_ROWS);

    // Sweep every address on reset or clear request; accept writes when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            clr_addr_q <= '0;
            wr_ready_q <= 1'b0;
            clr_busy_q <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT, ST_CLEAR: begin
                    if (clr_addr_q == AW'(DEPTH - 1)) begin
                        state_q    <= ST_IDLE;
                        clr_addr_q <= '0;
                        wr_ready_q <= 1'b1;
                        clr_busy_q <= 1'b0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clr_req) begin
                        state_q    <= ST_CLEAR;
                        clr_addr_q <= '0;
                        wr_ready_q <= 1'b0;
                        clr_busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_INIT;
                    clr_addr_q <= '0;
                    wr_ready_q <= 1'b0;
                    clr_busy_q <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ready = wr_ready_q;
    assign clr_busy = clr_busy_q;

    // RAM write mux: sweep address while clearing, else a validated user write.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_addr_q;
        ram_wdata = EMPTY;
        if (state_q != ST_IDLE) begin
            ram_we = 1'b1;
        end else if (wr_valid && !clr_req && wr_in_range) begin
            ram_we    = 1'b1;
            ram_waddr = AW'((32'(wr_board) * GRID_ROWS + 32'(wr_row)) * GRID_COLS + 32'(wr_col));
            ram_wdata = wr_state;
        end
    end

    // ---------------- cursor blink ----------------
    logic       vsync_prev_q;
    logic [7:0] blink_cnt_q;
    logic       blink_on_q;

    // Count frames on vsync rising edges and flip the phase every BLINK_FRAMES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev_q <= 1'b0;
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
        end else begin
            vsync_prev_q <= vga_in.vsync;
            if (vga_in.vsync && !vsync_prev_q) begin
                if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                    blink_cnt_q <= '0;
                    blink_on_q  <= ~blink_on_q;
                end else begin
                    blink_cnt_q <= blink_cnt_q + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 0: geometry ----------------
    vga_sig_t      vin_s;
    logic [31:0]   hpos, vpos;
    logic [31:0]   rel_x, rel_y, col, row, x_off, y_off;
    logic          in_y, in_board_d, grid_d, cell_d, cur_ok, cursor_d;
    logic [1:0]    board_d;
    logic [AW-1:0] rd_addr;
    logic [1:0]    rd_data;

    assign vin_s = '{hcount: vga_in.hcount, hsync: vga_in.hsync, hblnk: vga_in.hblnk,
                     vcount: vga_in.vcount, vsync: vga_in.vsync, vblnk: vga_in.vblnk,
                     rgb: vga_in.rgb};
    assign hpos  = 32'(vga_in.hcount);
    assign vpos  = 32'(vga_in.vcount);

    // Locate the board, cell and in-cell offset of the incoming pixel.
    always_comb begin
        in_board_d = 1'b0;
        board_d    = '0;
        rel_x      = '0;
        rel_y      = vpos - BOARD_Y0;
        in_y       = (vpos >= BOARD_Y0) && (vpos <= BOARD_Y0 + BOARD_H);
        for (int unsigned b = 0; b < N_BOARDS; b++) begin
            if (in_y && (hpos >= BOARD_X0 + b * BOARD_PITCH) &&
                (hpos <= BOARD_X0 + b * BOARD_PITCH + BOARD_W)) begin
                in_board_d = 1'b1;
                board_d    = 2'(b);
                rel_x      = hpos - (BOARD_X0 + b * BOARD_PITCH);
            end
        end
        col    = rel_x >> CELL_LOG2;
        row    = rel_y >> CELL_LOG2;
        x_off  = rel_x & (CELL_PX - 1);
        y_off  = rel_y & (CELL_PX - 1);
        // The inclusive far edge always has zero offset, so non-grid
        // pixels inside a board are always inside a real cell.
        grid_d = in_board_d && ((x_off == 0) || (y_off == 0));
        cell_d = in_board_d && !grid_d;
        rd_addr = '0;
        if (cell_d) begin
            rd_addr = AW'((32'(board_d) * GRID_ROWS + row) * GRID_COLS + col);
        end
        cur_ok   = cur_en && blink_on_q &&
                   (32'(cur_board) < N_BOARDS) &&
                   (32'(cur_col) < GRID_COLS) &&
                   (32'(cur_row) < GRID_ROWS);
        cursor_d = cell_d && cur_ok && (board_d == cur_board) &&
                   (col == 32'(cur_col)) && (row == 32'(cur_row)) &&
                   ((x_off < 2) || (x_off >= CELL_PX - 2) ||
                    (y_off < 2) || (y_off >= CELL_PX - 2));
    end

    cell_state_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_cell_state_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // ---------------- stage 1: colour ----------------
    vga_sig_t   s1_q, out_q, out_d;
    logic       s1_in_board_q, s1_grid_q, s1_cursor_q;
    logic [1:0] s1_board_q;
    logic [11:0] rgb_d;

    // Stage-0 register: timing plus geometry flags, aligned with the RAM read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q          <= '0;
            s1_in_board_q <= 1'b0;
            s1_grid_q     <= 1'b0;
            s1_cursor_q   <= 1'b0;
            s1_board_q    <= '0;
        end else begin
            s1_q          <= vin_s;
            s1_in_board_q <= in_board_d;
            s1_grid_q     <= grid_d;
            s1_cursor_q   <= cursor_d;
            s1_board_q    <= board_d;
        end
    end

    // Colour priority: blanking, screen edges, grid, cursor, cell, background.
    always_comb begin
        rgb_d = COL_BACKGROUND;
        if (s1_q.hblnk || s1_q.vblnk) begin
            rgb_d = COL_BLACK;
        end else if (s1_q.vcount == 11'd0) begin
            rgb_d = COL_YELLOW;
        end else if (s1_q.vcount == 11'(VER_PIXELS - 1)) begin
            rgb_d = COL_RED;
        end else if (s1_q.hcount == 11'd0) begin
            rgb_d = COL_GREEN;
        end else if (s1_q.hcount == 11'(HOR_PIXELS - 1)) begin
            rgb_d = COL_BLUE;
        end else if (s1_grid_q) begin
            rgb_d = COL_BLACK;
        end else if (s1_cursor_q) begin
            rgb_d = COL_WHITE;
        end else if (s1_in_board_q) begin
            case (cell_state_t'(rd_data))
                SHIP:    rgb_d = COL_GREY;
                HIT:     rgb_d = COL_RED;
                MISS:    rgb_d = COL_BLUE;
                default: rgb_d = BOARD_COLOUR[s1_board_q];
            endcase
        end
        out_d     = s1_q;
        out_d.rgb = rgb_d;
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign vga_out.hcount = out_q.hcount;
    assign vga_out.hsync  = out_q.hsync;
    assign vga_out.hblnk  = out_q.hblnk;
    assign vga_out.vcount = out_q.vcount;
    assign vga_out.vsync  = out_q.vsync;
    assign vga_out.vblnk  = out_q.vblnk;
    assign vga_out.rgb    = out_q.rgb;

endmodule
